// File: rtl/ttt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ttt_pkg
// Purpose  : Shared types and constants for the tic-tac-toe game controller:
//            FSM state encoding, player and winner codes, win-line masks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [2:0] {
    ST_PLAY  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WIN_P = 3'd2,
    ST_WIN_G = 3'd3,
    ST_DRAW  = 3'd4
  } state_t;

  // Player encoding, as carried on the turn output.
  localparam logic PURPLE = 1'b0;
  localparam logic GOLD   = 1'b1;

  // Winner codes.
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_PURP = 2'b01;
  localparam logic [1:0] WINNER_GOLD = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  // Win lines, bit i = cell i (row-major). Index 0 is the top row.
  // Rows 007/038/1C0, columns 049/092/124, diagonals 111/054.
  localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_LINES = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

endpackage : ttt_pkg
`default_nettype wire

// File: rtl/ttt_game_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ttt_game_ctrl_if
// Purpose  : Move-request and board-status bundle of the game controller.
//            master : drives new_game / move_valid / move_idx, observes status
//            slave  : the controller; returns move_ready, purp, gold, turn,
//                     illegal, game_over, winner
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface ttt_game_ctrl_if;

  logic       new_game;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic [8:0] purp;
  logic [8:0] gold;
  logic       turn;
  logic       illegal;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output new_game, move_valid, move_idx,
    input  move_ready, purp, gold, turn, illegal, game_over, winner
  );

  modport slave (
    input  new_game, move_valid, move_idx,
    output move_ready, purp, gold, turn, illegal, game_over, winner
  );

endinterface : ttt_game_ctrl_if
`default_nettype wire

// File: rtl/ttt_win_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ttt_win_detect
// Purpose  : Combinational three-in-a-row detector for one side's board.
// Ports    : board in 9  - occupancy vector of one side (bit i = cell i)
//            win   out 1 - at least one win line fully occupied
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board,
  output logic                 win
);

  logic [NUM_LINES-1:0] w_hit;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    assign w_hit[g] = ((board & WIN_LINES[g]) == WIN_LINES[g]);
  end

  assign win = |w_hit;

endmodule : ttt_win_detect
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ttt_game_ctrl
// Purpose  : Game-state controller for the 3x3 board. Accepts moves with
//            purple moving first, rejects occupied / out-of-range cells,
//            detects win or draw and holds the result until new_game.
// Ports    : clk     in  - system clock (shared with the renderer)
//            reset_n in  - asynchronous active-low reset
//            bus     slave modport of ttt_game_ctrl_if (move request in,
//                    registered board / turn / result status out)
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module ttt_game_ctrl
  import ttt_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  ttt_game_ctrl_if.slave bus
);

  state_t                 r_state,      w_state;
  logic [NUM_CELLS-1:0]   r_purp,       w_purp;
  logic [NUM_CELLS-1:0]   r_gold,       w_gold;
  logic                   r_turn,       w_turn;
  logic [3:0]             r_move_count, w_move_count;
  logic                   r_illegal,    w_illegal;
  logic [1:0]             r_winner,     w_winner;

  logic [NUM_CELLS-1:0]   w_cell_mask;
  logic                   w_legal;
  logic [NUM_CELLS-1:0]   w_mover_board;
  logic                   w_win;

  // Shifting by 9..15 leaves the mask empty; the range test still rejects.
  assign w_cell_mask = 9'b1 << bus.move_idx;
  assign w_legal     = (bus.move_idx < 4'(NUM_CELLS)) &&
                       (((r_purp | r_gold) & w_cell_mask) == '0);

  // In CHECK the side that just moved is still the current turn.
  assign w_mover_board = (r_turn == GOLD) ? r_gold : r_purp;

  ttt_win_detect u_win_detect (
    .board (w_mover_board),
    .win   (w_win)
  );

  always_comb begin
    w_state      = r_state;
    w_purp       = r_purp;
    w_gold       = r_gold;
    w_turn       = r_turn;
    w_move_count = r_move_count;
    w_illegal    = 1'b0;
    w_winner     = r_winner;

    if (bus.new_game) begin
      // Overrides any simultaneous move request and any pending evaluation.
      w_state      = ST_PLAY;
      w_purp       = '0;
      w_gold       = '0;
      w_turn       = PURPLE;
      w_move_count = '0;
      w_winner     = WINNER_NONE;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (bus.move_valid) begin
            if (w_legal) begin
              if (r_turn == GOLD) w_gold = r_gold | w_cell_mask;
              else                w_purp = r_purp | w_cell_mask;
              if (r_move_count != 4'(NUM_CELLS))
                w_move_count = r_move_count + 4'd1;
              w_state = ST_CHECK;
            end else begin
              w_illegal = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // Win is tested before the draw so a 9th-move win is reported.
          if (w_win) begin
            w_state  = (r_turn == GOLD) ? ST_WIN_G : ST_WIN_P;
            w_winner = (r_turn == GOLD) ? WINNER_GOLD : WINNER_PURP;
          end else if (r_move_count == 4'(NUM_CELLS)) begin
            w_state  = ST_DRAW;
            w_winner = WINNER_DRAW;
          end else begin
            w_turn  = ~r_turn;
            w_state = ST_PLAY;
          end
        end
        default: begin
          // Terminal states: everything frozen until new_game.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_PLAY;
      r_purp       <= '0;
      r_gold       <= '0;
      r_turn       <= PURPLE;
      r_move_count <= '0;
      r_illegal    <= 1'b0;
      r_winner     <= WINNER_NONE;
    end else begin
      r_state      <= w_state;
      r_purp       <= w_purp;
      r_gold       <= w_gold;
      r_turn       <= w_turn;
      r_move_count <= w_move_count;
      r_illegal    <= w_illegal;
      r_winner     <= w_winner;
    end
  end

  // Status outputs come straight from registers.
  assign bus.move_ready = (r_state == ST_PLAY);
  assign bus.game_over  = (r_state == ST_WIN_P) || (r_state == ST_WIN_G) ||
                          (r_state == ST_DRAW);
  assign bus.purp       = r_purp;
  assign bus.gold       = r_gold;
  assign bus.turn       = r_turn;
  assign bus.illegal    = r_illegal;
  assign bus.winner     = r_winner;

endmodule : ttt_game_ctrl
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_ttt_game_ctrl
// Purpose  : Directed self-checking bench for ttt_game_ctrl. Inputs change
//            1 time unit after a rising edge; outputs are sampled there too.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_ttt_game_ctrl;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  ttt_game_ctrl_if bus ();

  ttt_game_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full move: request edge, then the CHECK edge.
  task automatic play(input logic [3:0] idx);
    bus.move_valid = 1'b1;
    bus.move_idx   = idx;
    tick();
    bus.move_valid = 1'b0;
    tick();
  endtask

  task automatic start_new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.new_game   = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_idx   = 4'd0;
    reset_n        = 1'b0;
    #12;
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_purp",   32'(bus.purp),       32'h000);
    chk("rst_gold",   32'(bus.gold),       32'h000);
    chk("rst_turn",   32'(bus.turn),       32'd0);
    chk("rst_ready",  32'(bus.move_ready), 32'd1);
    chk("rst_illeg",  32'(bus.illegal),    32'd0);
    chk("rst_over",   32'(bus.game_over),  32'd0);
    chk("rst_winner", 32'(bus.winner),     32'd0);

    // Purple row win: 0,3,1,4,2 with a look inside the first CHECK cycle
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd0;
    tick();
    bus.move_valid = 1'b0;
    chk("chk_ready_low", 32'(bus.move_ready), 32'd0);
    chk("chk_purp",      32'(bus.purp),       32'h001);
    chk("chk_turn_hold", 32'(bus.turn),       32'd0);
    tick();
    chk("after_chk_ready", 32'(bus.move_ready), 32'd1);
    chk("after_chk_turn",  32'(bus.turn),       32'd1);
    play(4'd3);
    play(4'd1);
    play(4'd4);
    play(4'd2);
    chk("rowwin_purp",   32'(bus.purp),       32'h007);
    chk("rowwin_gold",   32'(bus.gold),       32'h018);
    chk("rowwin_winner", 32'(bus.winner),     32'd1);
    chk("rowwin_over",   32'(bus.game_over),  32'd1);
    chk("rowwin_ready",  32'(bus.move_ready), 32'd0);

    start_new_game();
    chk("ng_purp",   32'(bus.purp),      32'h000);
    chk("ng_winner", 32'(bus.winner),    32'd0);
    chk("ng_over",   32'(bus.game_over), 32'd0);
    chk("ng_turn",   32'(bus.turn),      32'd0);

    // Occupied and out-of-range requests
    play(4'd4);
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd4;
    tick();
    bus.move_valid = 1'b0;
    chk("occ_illegal", 32'(bus.illegal),    32'd1);
    chk("occ_gold",    32'(bus.gold),       32'h000);
    chk("occ_turn",    32'(bus.turn),       32'd1);
    chk("occ_ready",   32'(bus.move_ready), 32'd1);
    tick();
    chk("occ_pulse_end", 32'(bus.illegal), 32'd0);
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd12;
    tick();
    bus.move_valid = 1'b0;
    chk("oor_illegal", 32'(bus.illegal), 32'd1);
    chk("oor_purp",    32'(bus.purp),    32'h010);
    chk("oor_gold",    32'(bus.gold),    32'h000);
    tick();
    chk("oor_pulse_end", 32'(bus.illegal), 32'd0);
    play(4'd8);
    chk("after_illeg_gold", 32'(bus.gold), 32'h100);
    chk("after_illeg_turn", 32'(bus.turn), 32'd0);

    // Draw: 0,1,2,4,3,5,7,6,8
    start_new_game();
    play(4'd0); play(4'd1); play(4'd2); play(4'd4); play(4'd3);
    play(4'd5); play(4'd7); play(4'd6);
    chk("pre_draw_over", 32'(bus.game_over), 32'd0);
    play(4'd8);
    chk("draw_purp",   32'(bus.purp),      32'h18D);
    chk("draw_gold",   32'(bus.gold),      32'h072);
    chk("draw_winner", 32'(bus.winner),    32'd3);
    chk("draw_over",   32'(bus.game_over), 32'd1);

    // Win on the ninth move beats draw: 0,1,2,4,3,5,7,8,6
    start_new_game();
    play(4'd0); play(4'd1); play(4'd2); play(4'd4); play(4'd3);
    play(4'd5); play(4'd7); play(4'd8); play(4'd6);
    chk("win9_purp",   32'(bus.purp),   32'h0CD);
    chk("win9_gold",   32'(bus.gold),   32'h132);
    chk("win9_winner", 32'(bus.winner), 32'd1);

    // new_game together with move_valid: move discarded, no illegal
    start_new_game();
    bus.new_game   = 1'b1;
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd0;
    tick();
    bus.new_game   = 1'b0;
    bus.move_valid = 1'b0;
    chk("sim_purp",    32'(bus.purp),       32'h000);
    chk("sim_gold",    32'(bus.gold),       32'h000);
    chk("sim_turn",    32'(bus.turn),       32'd0);
    chk("sim_illegal", 32'(bus.illegal),    32'd0);
    chk("sim_ready",   32'(bus.move_ready), 32'd1);

    // Asynchronous reset in the middle of CHECK
    play(4'd2);
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd6;
    tick();
    bus.move_valid = 1'b0;
    chk("pre_arst_gold",  32'(bus.gold),       32'h040);
    chk("pre_arst_ready", 32'(bus.move_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_purp",  32'(bus.purp),       32'h000);
    chk("arst_gold",  32'(bus.gold),       32'h000);
    chk("arst_turn",  32'(bus.turn),       32'd0);
    chk("arst_ready", 32'(bus.move_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Gold win (3,4,5), then a request on an empty cell while in WIN_G
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd8); play(4'd5);
    chk("gwin_winner", 32'(bus.winner), 32'd2);
    chk("gwin_gold",   32'(bus.gold),   32'h038);
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd2;
    tick();
    tick();
    bus.move_valid = 1'b0;
    chk("frz_purp",    32'(bus.purp),       32'h103);
    chk("frz_gold",    32'(bus.gold),       32'h038);
    chk("frz_illegal", 32'(bus.illegal),    32'd0);
    chk("frz_ready",   32'(bus.move_ready), 32'd0);
    chk("frz_turn",    32'(bus.turn),       32'd1);
    chk("frz_over",    32'(bus.game_over),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ttt_game_ctrl
`default_nettype wire
